// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage feeding decode.
//
// Holds the PC and fetches one 32-bit word at a time from instruction memory
// over a req/gnt + rvalid handshake, with at most one request outstanding.
// Fetched {pc, instr} pairs go to decode through a valid/ready output register
// backed by a one-entry skid buffer. Redirects from execute flush the pipe and
// reload the PC. A misaligned target produces a single fault entry (NOP_INSTR,
// out_fault=1) and halts fetch until the next redirect.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req/addr     fetch request and byte address (addr always equals pc)
//   imem_gnt          request accepted this cycle
//   imem_rvalid/rdata response valid and instruction word
//   redirect_valid/pc flush and new PC from execute
//   out_valid/ready   handshake towards decode
//   out_instr/pc      instruction word and its address
//   out_fault         misaligned-target marker
//
// State  | meaning
// S_IDLE | first cycle after reset release
// S_REQ  | request pc (held off while the skid buffer is full)
// S_WAIT | request granted, waiting for rvalid (drop=1: discard the response)
// S_FAULT| misaligned redirect delivered; idle until the next redirect
module if_fetch #(
  parameter int unsigned      XLEN      = 64,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_fault
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [1:0]      state;
  logic [XLEN-1:0] pc;
  logic            drop;
  logic            fault_pend;
  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;

  logic granted;
  logic resp;
  logic capture;
  logic xfer;
  logic redir_misal;
  logic inflight;

  assign imem_addr   = pc;
  // A full skid buffer means there is nowhere to put another response.
  assign imem_req    = (state == S_REQ) && !skid_valid;
  assign granted     = imem_req && imem_gnt;
  assign resp        = (state == S_WAIT) && imem_rvalid;
  assign capture     = resp && !drop && !redirect_valid;
  assign xfer        = out_valid && out_ready;
  assign redir_misal = (redirect_pc[1:0] != 2'b00);
  // A request is still owed a response after this cycle.
  assign inflight    = granted || ((state == S_WAIT) && !imem_rvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      fault_pend <= 1'b0;
    end else if (redirect_valid) begin
      pc         <= redirect_pc;
      fault_pend <= redir_misal;
      if (inflight) begin
        // Absorb the stale response first; fault_pend picks the exit state.
        state <= S_WAIT;
        drop  <= 1'b1;
      end else begin
        state <= redir_misal ? S_FAULT : S_REQ;
        drop  <= 1'b0;
      end
    end else begin
      case (state)
        S_IDLE:  state <= S_REQ;
        S_REQ:   if (granted) state <= S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            drop <= 1'b0;
            if (drop) begin
              state <= fault_pend ? S_FAULT : S_REQ;
            end else begin
              pc    <= pc + PC_STEP;
              state <= S_REQ;
            end
          end
        end
        S_FAULT: state <= S_FAULT;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_pc     <= '0;
      out_fault  <= 1'b0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (redirect_valid) begin
      // Any transfer this cycle has already completed; the flush follows it.
      skid_valid <= 1'b0;
      out_valid  <= redir_misal;
      if (redir_misal) begin
        out_pc    <= redirect_pc;
        out_instr <= NOP_INSTR;
        out_fault <= 1'b1;
      end
    end else if (capture && (!out_valid || out_ready)) begin
      // Skid is always empty here: no request is issued while it is full.
      out_valid <= 1'b1;
      out_pc    <= pc;
      out_instr <= imem_rdata;
      out_fault <= 1'b0;
    end else if (capture) begin
      skid_valid <= 1'b1;
      skid_pc    <= pc;
      skid_instr <= imem_rdata;
    end else if (xfer) begin
      if (skid_valid) begin
        out_pc     <= skid_pc;
        out_instr  <= skid_instr;
        out_fault  <= 1'b0;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  a_one_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req && imem_gnt) |=> !imem_req);

  a_req_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    imem_req |-> (imem_addr[1:0] == 2'b00));

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed scenario tasks plus a randomized run. A
// memory responder returns address-derived words; a stream-level scoreboard
// expects consecutive PCs from reset or the latest redirect.
module tb_if_fetch;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_fault;

  int n_cmp;
  int n_err;
  int xfer_count;
  int gnt_wait;
  int rv_wait;
  bit rand_mode;

  if_fetch #(.XLEN(64), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_fault(out_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // Instruction memory: grants after gnt_wait cycles, answers rv_wait cycles
  // after the cycle following the grant. A pending response survives reset so
  // that it shows up as a stray rvalid afterwards.
  initial begin : mem_model
    int gcnt, rcnt, gw;
    bit pending;
    logic [63:0] paddr;
    gcnt = 0; rcnt = 0; gw = 0; pending = 0; paddr = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      if (pending) begin
        if (rcnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = word_at(paddr);
          pending = 0;
        end else rcnt--;
      end else if (rst_n && imem_req) begin
        if (gcnt == 0) gw = rand_mode ? int'($urandom_range(0, 2)) : gnt_wait;
        if (gcnt >= gw) begin
          imem_gnt = 1'b1;
          paddr = imem_addr;
          pending = 1;
          rcnt = rand_mode ? int'($urandom_range(0, 3)) : rv_wait;
          gcnt = 0;
        end else gcnt++;
      end
    end
  end

  // Stream scoreboard plus hold-stability checks, sampled late in each cycle.
  initial begin : scoreboard
    logic [63:0] exp_pc, pc_prev, addr_prev;
    logic [31:0] exp_instr, instr_prev;
    logic fault_prev;
    bit exp_fault, exp_none, hold_prev, req_prev;
    exp_pc = RESET_PC; exp_fault = 0; exp_none = 0; hold_prev = 0; req_prev = 0;
    pc_prev = '0; addr_prev = '0; instr_prev = '0; fault_prev = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        exp_pc = RESET_PC; exp_fault = 0; exp_none = 0; hold_prev = 0; req_prev = 0;
      end else begin
        if (hold_prev) begin
          n_cmp++;
          if (out_valid !== 1'b1 || out_pc !== pc_prev || out_instr !== instr_prev || out_fault !== fault_prev) begin
            n_err++;
            $display("FAIL out_stable: got v=%b pc=%h instr=%h f=%b, required v=1 pc=%h instr=%h f=%b",
                     out_valid, out_pc, out_instr, out_fault, pc_prev, instr_prev, fault_prev);
          end
        end
        if (req_prev) begin
          n_cmp++;
          if (imem_req !== 1'b1 || imem_addr !== addr_prev) begin
            n_err++;
            $display("FAIL req_stable: got req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, addr_prev);
          end
        end
        if (out_valid && out_ready) begin
          n_cmp++;
          xfer_count++;
          if (exp_none) begin
            n_err++;
            $display("FAIL stream_extra: got pc=%h instr=%h, required no output after fault", out_pc, out_instr);
          end else begin
            exp_instr = exp_fault ? NOP : word_at(exp_pc);
            if (out_pc !== exp_pc || out_instr !== exp_instr || out_fault !== exp_fault) begin
              n_err++;
              $display("FAIL stream: got pc=%h instr=%h f=%b, required pc=%h instr=%h f=%b",
                       out_pc, out_instr, out_fault, exp_pc, exp_instr, exp_fault);
            end
            if (exp_fault) exp_none = 1;
            else exp_pc = exp_pc + 64'd4;
          end
        end
        if (redirect_valid) begin
          exp_pc = redirect_pc;
          exp_fault = (redirect_pc[1:0] != 2'b00);
          exp_none = 0;
        end
        hold_prev = out_valid && !out_ready && !redirect_valid;
        req_prev  = imem_req && !imem_gnt && !redirect_valid;
        pc_prev = out_pc; instr_prev = out_instr; fault_prev = out_fault; addr_prev = imem_addr;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({imem_req, out_valid, out_fault} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got req=%b valid=%b fault=%b, required 0 0 0", imem_req, out_valid, out_fault);
    end
    n_cmp++;
    if (out_pc !== 64'h0 || out_instr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data: got pc=%h instr=%h, required 0 0", out_pc, out_instr);
    end
    n_cmp++;
    if (imem_addr !== RESET_PC) begin
      n_err++;
      $display("FAIL reset_addr: got %h, required %h", imem_addr, RESET_PC);
    end
  endtask

  task automatic test_basic();
    logic [63:0] epc;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      n_cmp++;
      if (c >= 3 && (c % 2) == 1) begin
        epc = 64'((c - 3) / 2 * 4);
        if (out_valid !== 1'b1 || out_pc !== epc || out_instr !== word_at(epc)) begin
          n_err++;
          $display("FAIL basic_cycle%0d: got v=%b pc=%h instr=%h, required v=1 pc=%h instr=%h",
                   c, out_valid, out_pc, out_instr, epc, word_at(epc));
        end
      end else if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL basic_cycle%0d: got valid=%b, required 0", c, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    bit found;
    logic [63:0] got[$];
    out_ready = 1'b1;
    apply_reset();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_pc == 64'h4) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL bp_find: got no out_pc=4 within 40 cycles, required one");
      return;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 64'h4) begin
        n_err++;
        $display("FAIL bp_hold%0d: got v=%b pc=%h, required v=1 pc=4", i, out_valid, out_pc);
      end
      if (i >= 2) begin
        n_cmp++;
        if (imem_req !== 1'b0) begin
          n_err++;
          $display("FAIL bp_noreq%0d: got req=%b, required 0", i, imem_req);
        end
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && got.size() < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (out_valid && out_ready) got.push_back(out_pc);
    end
    n_cmp++;
    if (got.size() != 3 || got[0] !== 64'h4 || got[1] !== 64'h8 || got[2] !== 64'hC) begin
      n_err++;
      $display("FAIL bp_drain: got %0d entries first=%h, required 4 8 C", got.size(),
               (got.size() > 0) ? got[0] : 64'hx);
    end
  endtask

  task automatic test_redirect();
    bit found;
    logic [63:0] tgt;
    for (int k = 0; k < 2; k++) begin
      rv_wait = (k == 0) ? 0 : 3;
      tgt = (k == 0) ? 64'h100 : 64'h180;
      out_ready = 1'b1;
      apply_reset();
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
        @(negedge clk);
        if (imem_req && imem_addr == 64'h10) found = 1;
      end
      n_cmp++;
      if (!found) begin
        n_err++;
        $display("FAIL redir_find%0d: got no request for 0x10, required one", k);
        continue;
      end
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = tgt;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL redir_flush%0d: got valid=%b, required 0", k, out_valid);
      end
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
        @(negedge clk);
        if (out_valid && out_ready) found = 1;
      end
      n_cmp++;
      if (!found || out_pc !== tgt || out_instr !== word_at(tgt)) begin
        n_err++;
        $display("FAIL redir_target%0d: got found=%b pc=%h instr=%h, required pc=%h instr=%h",
                 k, found, out_pc, out_instr, tgt, word_at(tgt));
      end
    end
    rv_wait = 0;
  endtask

  task automatic test_fault();
    bit found;
    out_ready = 1'b1;
    apply_reset();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_pc == 64'h8) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL fault_find: got no out_pc=8, required one");
      return;
    end
    redirect_valid = 1'b1;
    redirect_pc = 64'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_cmp++;
    if ({out_valid, out_pc, out_instr, out_fault} !== {1'b1, 64'h102, NOP, 1'b1}) begin
      n_err++;
      $display("FAIL fault_entry: got v=%b pc=%h instr=%h f=%b, required v=1 pc=102 instr=%h f=1",
               out_valid, out_pc, out_instr, out_fault, NOP);
    end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b0 || (i > 0 && out_valid !== 1'b0)) begin
        n_err++;
        $display("FAIL fault_idle%0d: got req=%b valid=%b, required req=0", i, imem_req, out_valid);
      end
    end
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 64'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (i > 0) @(negedge clk);
      if (out_valid && out_ready) found = 1;
    end
    n_cmp++;
    if (!found || out_pc !== 64'h200 || out_fault !== 1'b0 || out_instr !== word_at(64'h200)) begin
      n_err++;
      $display("FAIL fault_resume: got found=%b pc=%h f=%b instr=%h, required pc=200 f=0 instr=%h",
               found, out_pc, out_fault, out_instr, word_at(64'h200));
    end
  endtask

  task automatic test_stall();
    bit found;
    gnt_wait = 5;
    rv_wait = 4;
    out_ready = 1'b1;
    apply_reset();
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 64'h8) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL stall_find: got no request for 0x8, required one");
    end else begin
      for (int i = 1; i <= 5; i++) begin
        @(negedge clk);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h8) begin
          n_err++;
          $display("FAIL stall_hold%0d: got req=%b addr=%h, required req=1 addr=8", i, imem_req, imem_addr);
        end
      end
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
        @(negedge clk);
        if (out_valid && out_ready) found = 1;
      end
      n_cmp++;
      if (!found || out_pc !== 64'h8 || out_instr !== word_at(64'h8)) begin
        n_err++;
        $display("FAIL stall_data: got found=%b pc=%h instr=%h, required pc=8 instr=%h",
                 found, out_pc, out_instr, word_at(64'h8));
      end
    end
    gnt_wait = 0;
    rv_wait = 0;
  endtask

  task automatic test_reset_midwait();
    bit found;
    rv_wait = 6;
    out_ready = 1'b1;
    apply_reset();
    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 64'h8) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL rstw_find: got no request for 0x8, required one");
    end else begin
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({imem_req, out_valid, out_fault, out_pc, out_instr} !== {3'b000, 64'h0, 32'h0} ||
          imem_addr !== RESET_PC) begin
        n_err++;
        $display("FAIL rstw_values: got req=%b v=%b f=%b pc=%h instr=%h addr=%h, required all 0, addr=%h",
                 imem_req, out_valid, out_fault, out_pc, out_instr, imem_addr, RESET_PC);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
        @(negedge clk);
        if (out_valid && out_ready) found = 1;
      end
      n_cmp++;
      if (!found || out_pc !== RESET_PC || out_instr !== word_at(RESET_PC)) begin
        n_err++;
        $display("FAIL rstw_restart: got found=%b pc=%h instr=%h, required pc=%h instr=%h",
                 found, out_pc, out_instr, RESET_PC, word_at(RESET_PC));
      end
    end
    rv_wait = 0;
  endtask

  task automatic test_random();
    int start;
    rand_mode = 1;
    apply_reset();
    start = xfer_count;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc = 64'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 4) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    rand_mode = 0;
    n_cmp++;
    if (xfer_count - start < 100) begin
      n_err++;
      $display("FAIL rand_progress: got %0d transfers, required at least 100", xfer_count - start);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; xfer_count = 0;
    gnt_wait = 0; rv_wait = 0; rand_mode = 0;
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_fault();
    test_stall();
    test_reset_midwait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
